// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: hazard, memory-wait, exception and divider arbitration.
// Optional stall-cycle counter built only when PIPE_STALL_CNT_EN is defined.
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lwstallD,
  input  logic        branchstallD,
  input  logic        i_stall,
  input  logic        d_stall,
  input  logic        div_E,
  input  logic        div_done,
  input  logic        except_M,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        div_start,
  output logic        div_abort,
  output logic        div_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, DIV} state_t;

  localparam logic [5:0] LAST = 6'(DIV_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       lockout, lockout_nxt;

  logic haz, take_exc, start_ok, div_wait, div_expire;

  assign haz        = lwstallD | branchstallD;
  assign take_exc   = except_M & ~d_stall;
  assign start_ok   = (state == RUN) & div_E & ~lockout;
  assign div_wait   = (state == DIV) & ~div_done & (cnt < LAST);
  assign div_expire = (state == DIV) & ~div_done & (cnt >= LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= RUN;
      cnt     <= '0;
      lockout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      lockout <= lockout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lockout_nxt = 1'b0;
    if (take_exc) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        RUN: begin
          // Lockout survives a memory wait so a held, completed divide is not restarted.
          lockout_nxt = lockout & d_stall;
          if (start_ok && !d_stall) begin
            state_nxt = DIV;
            cnt_nxt   = '0;
          end
        end
        DIV: begin
          if (div_done) begin
            state_nxt   = RUN;
            cnt_nxt     = '0;
            lockout_nxt = 1'b1;
          end else if (div_wait) begin
            cnt_nxt = cnt + 6'd1;
          end else if (!d_stall) begin
            // Expiry is held off during a memory wait so the abort pulse is not lost.
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushM      = 1'b0;
    flushW      = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    div_timeout = 1'b0;
    if (resetn) begin
      if (take_exc) begin
        flushD    = 1'b1;
        flushE    = 1'b1;
        flushM    = 1'b1;
        div_abort = (state == DIV);
      end else if (d_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (start_ok || div_wait) begin
        div_start = start_ok;
        stallF    = 1'b1;
        stallD    = 1'b1;
        stallE    = 1'b1;
        flushM    = 1'b1;
      end else begin
        stallF      = i_stall | haz;
        stallD      = haz;
        flushE      = haz;
        flushD      = i_stall & ~haz;
        div_abort   = div_expire;
        div_timeout = div_expire;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stallF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second instance with DIV_TIMEOUT=4 covers divider expiry.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic resetn, lwstallD, branchstallD, i_stall, d_stall, div_E, div_done, except_M;

  logic        sF, sD, sE, sM, fD, fE, fM, fW, dS, dA, dT;
  logic        sF4, sD4, sE4, sM4, fD4, fE4, fM4, fW4, dS4, dA4, dT4;
  logic [31:0] sc, sc4;
  logic [10:0] o, o4;

  int checks = 0;
  int errors = 0;
  int stall_tally;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .resetn(resetn), .lwstallD(lwstallD), .branchstallD(branchstallD),
    .i_stall(i_stall), .d_stall(d_stall), .div_E(div_E), .div_done(div_done), .except_M(except_M),
    .stallF(sF), .stallD(sD), .stallE(sE), .stallM(sM),
    .flushD(fD), .flushE(fE), .flushM(fM), .flushW(fW),
    .div_start(dS), .div_abort(dA), .div_timeout(dT), .stall_cycles(sc)
  );

  pipe_ctrl #(.DIV_TIMEOUT(4)) dut4 (
    .clk(clk), .resetn(resetn), .lwstallD(lwstallD), .branchstallD(branchstallD),
    .i_stall(i_stall), .d_stall(d_stall), .div_E(div_E), .div_done(div_done), .except_M(except_M),
    .stallF(sF4), .stallD(sD4), .stallE(sE4), .stallM(sM4),
    .flushD(fD4), .flushE(fE4), .flushM(fM4), .flushW(fW4),
    .div_start(dS4), .div_abort(dA4), .div_timeout(dT4), .stall_cycles(sc4)
  );

  // Bit order: stallF stallD stallE stallM | flushD flushE flushM flushW | div_start div_abort div_timeout
  assign o  = {sF, sD, sE, sM, fD, fE, fM, fW, dS, dA, dT};
  assign o4 = {sF4, sD4, sE4, sM4, fD4, fE4, fM4, fW4, dS4, dA4, dT4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lw, input logic br, input logic is, input logic ds,
                       input logic de, input logic dd, input logic ex);
    lwstallD = lw; branchstallD = br; i_stall = is; d_stall = ds;
    div_E = de; div_done = dd; except_M = ex;
    #2;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    nxt();
    resetn = 1'b1;
  endtask

  initial begin
    // Reset with every input high: outputs must stay quiet.
    resetn = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 1);
    chk("reset_out", 32'(o), 32'h0);
    chk("reset_out4", 32'(o4), 32'h0);
    chk("reset_cnt", sc, 32'h0);
    nxt();
    resetn = 1'b1;

    drive(0, 0, 0, 0, 0, 0, 0);
    chk("idle", 32'(o), 32'h0);
    nxt();

    drive(1, 0, 0, 0, 0, 0, 0);
    chk("lwstall", 32'(o), 32'(11'b1100_0100_000));
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lwstall_after", 32'(o), 32'h0);
    nxt();

    drive(0, 0, 1, 0, 0, 0, 0);
    chk("istall", 32'(o), 32'(11'b1000_1000_000));
    nxt();
    drive(0, 1, 1, 0, 0, 0, 0);
    chk("br_istall", 32'(o), 32'(11'b1100_0100_000));
    nxt();

    // Divide completing after 5 DIV cycles.
    stall_tally = 0;
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("div_start", 32'(o), 32'(11'b1110_0010_100));
    if (sF) stall_tally++;
    nxt();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("div_wait", 32'(o), 32'(11'b1110_0010_000));
      if (sF) stall_tally++;
      nxt();
    end
    drive(0, 0, 0, 0, 1, 1, 0);
    chk("div_done", 32'(o), 32'h0);
    if (sF) stall_tally++;
    nxt();
    chk("div_stall_total", 32'(stall_tally), 32'd6);
    drive(0, 0, 0, 0, 1, 1, 0);
    chk("div_lockout", 32'(o), 32'h0);
    nxt();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("div_restart", 32'(o), 32'(11'b1110_0010_100));
    nxt();

    // Reset in the middle of DIV: silent, then RUN behaviour.
    resetn = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("rst_mid_div", 32'(o), 32'h0);
    chk("rst_mid_div_cnt", sc, 32'h0);
    nxt();
    resetn = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("post_rst_run", 32'(o), 32'(11'b1110_0010_100));
    chk("t4_start", 32'(o4), 32'(11'b1110_0010_100));
    nxt();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("t4_wait", 32'(o4), 32'(11'b1110_0010_000));
      nxt();
    end
    drive(0, 0, 1, 0, 1, 0, 0);
    chk("t4_timeout", 32'(o4), 32'(11'b1000_1000_011));
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t4_run_after", 32'(o4), 32'h0);
    nxt();

    // Exception in the 3rd DIV cycle.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0);
    nxt();
    drive(0, 0, 0, 0, 1, 0, 0);
    nxt();
    drive(0, 0, 0, 0, 1, 0, 0);
    nxt();
    drive(0, 0, 0, 0, 1, 0, 1);
    chk("exc_in_div", 32'(o), 32'(11'b0000_1110_010));
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("exc_run_after", 32'(o), 32'h0);
    nxt();

    // Same, but with a memory wait masking the exception.
    drive(0, 0, 0, 0, 1, 0, 0);
    nxt();
    drive(0, 0, 0, 0, 1, 0, 0);
    nxt();
    drive(0, 0, 0, 0, 1, 0, 0);
    nxt();
    drive(0, 0, 0, 1, 1, 0, 1);
    chk("exc_masked", 32'(o), 32'(11'b1111_0001_000));
    nxt();
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("still_div_haz", 32'(o), 32'(11'b1110_0010_000));
    nxt();
    drive(0, 0, 0, 0, 1, 1, 0);
    chk("done_after_mask", 32'(o), 32'h0);
    nxt();

`ifdef PIPE_STALL_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      nxt();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("stall_cnt", sc, 32'd3);
`else
    chk("stall_cnt_tied", sc, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: DIV_TIMEOUT, 40, max DIV-state cycles before the divider wait is abandoned (range 2..63).
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 lwstallD, branchstallD  in  1 each  load-use / branch-compare stall requests from hazard unit.
REQ-005 i_stall  in  1  instruction fetch not ready this cycle.
REQ-006 d_stall  in  1  data access in M not complete this cycle.
REQ-007 div_E  in  1  divide instruction present in E.
REQ-008 div_done  in  1  divider result valid (held until next div_start).
REQ-009 except_M  in  1  exception taken by the instruction in M.
REQ-010 stallF, stallD, stallE, stallM  out  1 each  hold the named stage register.
REQ-011 flushD, flushE, flushM, flushW  out  1 each  load a bubble into the named stage register.
REQ-012 div_start, div_abort, div_timeout  out  1 each  single-cycle divider control/status pulses.
REQ-013 stall_cycles  out  32  count of cycles with stallF high.

Function
REQ-014 FSM: two states, RUN and DIV; 6-bit wait counter cnt.
REQ-015 All stall/flush/div pulse outputs are combinational from state, cnt and inputs; priority: exception > d_stall > divider > i_stall/hazard.
REQ-016 Exception (except_M=1, d_stall=0): flushD=flushE=flushM=1, all stalls 0; div_abort=1 if state DIV; next state RUN.
REQ-017 except_M is ignored while d_stall=1.
REQ-018 d_stall=1: stallF=stallD=stallE=stallM=1, flushW=1, other flushes 0; FSM and cnt continue to advance.
REQ-019 RUN, div_E=1, no higher event: div_start=1, stallF=stallD=stallE=1, flushM=1; next state DIV, cnt<=0.
REQ-020 DIV, div_done=0, cnt<DIV_TIMEOUT-1: stallF=stallD=stallE=1, flushM=1; cnt increments.
REQ-021 DIV, div_done=1: no divider stall this cycle; E advances with result; next state RUN.
REQ-022 DIV, div_done=0, cnt==DIV_TIMEOUT-1: div_timeout=1, div_abort=1, divider stalls released; next state RUN.
REQ-023 div_start never asserted in DIV, nor in the cycle div_E is first seen after returning to RUN via REQ-021 (one-cycle lockout flag prevents restarting the completed divide).
REQ-024 No higher event: stallF=i_stall|lwstallD|branchstallD; stallD=lwstallD|branchstallD; flushE=lwstallD|branchstallD; flushD=i_stall&~stallD.
REQ-025 Divider stall active: hazard/i_stall terms OR into stallF/stallD only; flushD/flushE forced 0.
REQ-026 stallE/stallM/flushW/div pulses never asserted except as stated above.

Reset
REQ-027 resetn low: state RUN, cnt=0, lockout=0, stall_cycles=0, every 1-bit output 0 regardless of inputs.
REQ-028 resetn low mid-DIV aborts silently (no div_abort pulse); first cycle after release behaves as RUN.

Configuration
REQ-029 Macro PIPE_STALL_CNT_EN defined: stall_cycles increments each clock with stallF=1, wraps 0xFFFFFFFF->0.
REQ-030 Macro undefined: counter not built; stall_cycles tied to 0.

Verification
REQ-031 lwstallD=1 one cycle in RUN -> stallF=stallD=flushE=1 that cycle, state stays RUN.
REQ-032 div_E=1, div_done after 5 DIV cycles -> div_start one cycle, stallF/D/E high 6 cycles total, release on div_done, no second div_start.
REQ-033 DIV_TIMEOUT=4, div_done never -> div_timeout=div_abort=1 at 4th DIV cycle, state RUN next.
REQ-034 except_M in 3rd DIV cycle -> flushD/E/M=1, div_abort=1, stalls 0, RUN next; same with d_stall=1 -> except ignored, all four stalls + flushW.
REQ-035 PIPE_STALL_CNT_EN, stall_cycles preloaded near 0xFFFFFFFF, 3 stall cycles -> wraps to 0x00000001 (from 0xFFFFFFFE); resetn pulse mid-DIV -> all outputs 0, counter 0.
